// File: rtl/reg_readback_pkg.sv
// Shared definitions for the register read-back controller.
//   NREGS / IDX_W : register count and index width of the peripheral bank
//   state_e       : controller FSM states
//   byte_merge    : lane-wise merge of new write data over the old value
package reg_readback_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned IDX_W = 4;

  // Widest data bus the merge helper supports; callers cast in and out.
  localparam int unsigned MERGE_W     = 256;
  localparam int unsigned MERGE_LANES = MERGE_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  // Lane k of the result takes nw when sel[k] is set, otherwise old.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_LANES-1:0] sel,
    input logic [MERGE_W-1:0]     nw,
    input logic [MERGE_W-1:0]     old
  );
    logic [MERGE_W-1:0] res;
    res = old;
    for (int unsigned k = 0; k < MERGE_LANES; k++) begin
      if (sel[k]) res[8*k +: 8] = nw[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rb_shadow_ram.sv
// Shadow copy of the write-only peripheral registers.
//   clk_i : clock
//   we_i  : synchronous write enable
//   adr_i : register index (shared by read and write)
//   dat_i : write data
//   dat_o : asynchronous read data at adr_i
// Contents are deliberately not reset; validity is tracked by the owner.
module rb_shadow_ram
  import reg_readback_pkg::*;
#(
  parameter int unsigned WID = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] adr_i,
  input  logic [WID-1:0]   dat_i,
  output logic [WID-1:0]   dat_o
);

  logic [WID-1:0] mem [NREGS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[adr_i] <= dat_i;
  end

  assign dat_o = mem[adr_i];

endmodule

// File: rtl/reg_readback_ctrl.sv
// Bus-slave front end for a write-only peripheral register bank.
// Writes are forwarded to the peripheral with a ready handshake (with
// timeout) and mirrored into a shadow RAM; reads are served from the shadow.
//   clk_i, rst_ni              : clock, async active-low reset
//   cs_i, cyc_i, stb_i, we_i   : bus request qualifiers / direction
//   sel_i, adr_i, dat_i        : byte lanes, register index, write data
//   dat_o, ack_o, err_o        : read data, acknowledge, timeout error
//   reg_we_o, reg_adr_o,
//   reg_dat_o, reg_rdy_i       : peripheral write port and its ready
module reg_readback_ctrl
  import reg_readback_pkg::*;
#(
  parameter int unsigned     WID     = 16,
  parameter logic [WID-1:0]  RST_VAL = '0,
  parameter int unsigned     TMO     = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cs_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [WID/8-1:0]   sel_i,
  input  logic [IDX_W-1:0]   adr_i,
  input  logic [WID-1:0]     dat_i,
  output logic [WID-1:0]     dat_o,
  output logic               ack_o,
  output logic               err_o,
  output logic               reg_we_o,
  output logic [IDX_W-1:0]   reg_adr_o,
  output logic [WID-1:0]     reg_dat_o,
  input  logic               reg_rdy_i
);

  localparam logic [7:0] TMO_CNT = 8'(TMO);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   reg_adr_q, reg_adr_d;
  logic [WID-1:0]     reg_dat_q, reg_dat_d;
  logic               reg_we_q, reg_we_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [WID-1:0]     dat_q, dat_d;
  logic [NREGS-1:0]   valid_q, valid_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               req;
  logic               hold;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_adr;
  logic [WID-1:0]     ram_rdat;
  logic [WID-1:0]     cur_val;
  logic [7:0]         cnt_inc;

  assign req  = cs_i & cyc_i & stb_i;
  // cs_i is only sampled at acceptance, so the ack hold follows cyc/stb.
  assign hold = cyc_i & stb_i;

  // In IDLE the RAM is looked up at the incoming index for the byte merge;
  // afterwards it stays on the latched index for the write or the read.
  assign ram_adr = (state_q == ST_IDLE) ? adr_i : reg_adr_q;
  assign ram_we  = (state_q == ST_WR) & reg_rdy_i;
  assign cur_val = valid_q[ram_adr] ? ram_rdat : RST_VAL;
  assign cnt_inc = cnt_q + 8'd1;

  rb_shadow_ram #(.WID(WID)) u_shadow (
    .clk_i (clk_i),
    .we_i  (ram_we),
    .adr_i (ram_adr),
    .dat_i (reg_dat_q),
    .dat_o (ram_rdat)
  );

  always_comb begin
    state_d   = state_q;
    reg_adr_d = reg_adr_q;
    reg_dat_d = reg_dat_q;
    reg_we_d  = reg_we_q;
    ack_d     = ack_q;
    err_d     = err_q;
    dat_d     = dat_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          reg_adr_d = adr_i;
          if (we_i) begin
            reg_dat_d = WID'(byte_merge(MERGE_LANES'(sel_i), MERGE_W'(dat_i),
                                        MERGE_W'(cur_val)));
            reg_we_d  = 1'b1;
            cnt_d     = '0;
            state_d   = ST_WR;
          end else begin
            state_d   = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (reg_rdy_i) begin
          valid_d[reg_adr_q] = 1'b1;
          reg_we_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = ST_ACK;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_CNT) begin
            reg_we_d = 1'b0;
            err_d    = 1'b1;
            ack_d    = 1'b1;
            state_d  = ST_ACK;
          end
        end
      end
      ST_RD: begin
        dat_d   = cur_val;
        ack_d   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!hold) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          dat_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      reg_adr_q <= '0;
      reg_dat_q <= '0;
      reg_we_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      valid_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      reg_adr_q <= reg_adr_d;
      reg_dat_q <= reg_dat_d;
      reg_we_q  <= reg_we_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign reg_we_o  = reg_we_q;
  assign reg_adr_o = reg_adr_q;
  assign reg_dat_o = reg_dat_q;

endmodule

// File: tb/tb_reg_readback_ctrl.sv
module tb_reg_readback_ctrl;

  localparam int TMO   = 8;
  localparam int BOUND = 300;

  logic        clk;
  logic        rst_ni;
  logic        cs_i, cyc_i, stb_i, we_i;
  logic [1:0]  sel_i;
  logic [3:0]  adr_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack_o, err_o, reg_we_o;
  logic [3:0]  reg_adr_o;
  logic [15:0] reg_dat_o;
  logic        reg_rdy_i;

  reg_readback_ctrl #(.WID(16), .RST_VAL(16'hA5A5), .TMO(TMO)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .cs_i      (cs_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .sel_i     (sel_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .reg_we_o  (reg_we_o),
    .reg_adr_o (reg_adr_o),
    .reg_dat_o (reg_dat_o),
    .reg_rdy_i (reg_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int          rdy_wait;   // WR clocks with ready low before it rises
    int          hold;       // extra clocks the strobe stays up after ack
    logic [15:0] exp;        // expected reg_dat_o (write) or dat_o (read)
    logic        exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];
  vec_t vecs[17];
  vec_t v;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input string nm, input logic [15:0] act);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %0h want <scoreboard empty>", nm, act);
    end else begin
      e = sb_q.pop_front();
      check(nm, 32'(act), 32'(e));
    end
  endtask

  task automatic idle_bus();
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0; reg_rdy_i = 1'b0;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic xfer(input vec_t t);
    int lat, we_cnt, exp_lat;
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    we_i = t.we; adr_i = t.adr; dat_i = t.dat; sel_i = t.sel;
    reg_rdy_i = t.we && (t.rdy_wait == 0);
    sb_q.push_back(t.exp);
    @(posedge clk); @(negedge clk);
    // scramble fields that must have been latched at acceptance
    adr_i = ~t.adr; dat_i = ~t.dat; sel_i = ~t.sel;
    check("ack_early", 32'(ack_o), 32'(1'b0));
    check("reg_adr", 32'(reg_adr_o), 32'(t.adr));
    if (t.we) begin
      check("reg_we_start", 32'(reg_we_o), 32'(1'b1));
      pop_cmp("reg_dat", reg_dat_o);
    end else begin
      check("reg_we_rd", 32'(reg_we_o), 32'(1'b0));
    end
    exp_lat = t.we ? ((t.rdy_wait + 1 < TMO) ? t.rdy_wait + 1 : TMO) : 1;
    lat = 0;
    we_cnt = reg_we_o ? 1 : 0;
    for (int n = 1; n <= BOUND; n++) begin
      reg_rdy_i = t.we && (n > t.rdy_wait);
      @(posedge clk); @(negedge clk);
      if (reg_we_o) we_cnt++;
      if (ack_o) begin
        lat = n;
        break;
      end
    end
    reg_rdy_i = 1'b0;
    check("ack_latency", 32'(lat), 32'(exp_lat));
    check("err", 32'(err_o), 32'(t.exp_err));
    if (t.we) begin
      check("reg_we_clocks", 32'(we_cnt), 32'(exp_lat));
      check("wr_dat_o", 32'(dat_o), 32'(0));
    end else begin
      pop_cmp("rd_data", dat_o);
    end
    for (int h = 0; h < t.hold; h++) begin
      @(posedge clk); @(negedge clk);
      check("ack_hold", 32'(ack_o), 32'(1'b1));
    end
    idle_bus();
    @(posedge clk); @(negedge clk);
    check("ack_clear", 32'(ack_o), 32'(1'b0));
    check("err_clear", 32'(err_o), 32'(1'b0));
    check("dat_clear", 32'(dat_o), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    //           we    adr    dat       sel    rdy  hold exp       err
    vecs[0]  = '{1'b0, 4'h3, 16'h0000, 2'b11, 0,   0, 16'hA5A5, 1'b0};
    vecs[1]  = '{1'b1, 4'h5, 16'h1234, 2'b11, 0,   0, 16'h1234, 1'b0};
    vecs[2]  = '{1'b0, 4'h5, 16'h0000, 2'b11, 0,   0, 16'h1234, 1'b0};
    vecs[3]  = '{1'b1, 4'h5, 16'hFF00, 2'b10, 0,   0, 16'hFF34, 1'b0};
    vecs[4]  = '{1'b0, 4'h5, 16'h0000, 2'b11, 0,   0, 16'hFF34, 1'b0};
    vecs[5]  = '{1'b1, 4'h7, 16'hBEEF, 2'b11, 4,   0, 16'hBEEF, 1'b0};
    vecs[6]  = '{1'b0, 4'h7, 16'h0000, 2'b11, 0,   0, 16'hBEEF, 1'b0};
    vecs[7]  = '{1'b1, 4'h7, 16'h0000, 2'b11, 100, 0, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 4'h7, 16'h0000, 2'b11, 0,   0, 16'hBEEF, 1'b0};
    vecs[9]  = '{1'b1, 4'h2, 16'hABCD, 2'b00, 0,   0, 16'hA5A5, 1'b0};
    vecs[10] = '{1'b0, 4'h2, 16'h0000, 2'b11, 0,   0, 16'hA5A5, 1'b0};
    vecs[11] = '{1'b1, 4'h2, 16'h1122, 2'b01, 0,   0, 16'hA522, 1'b0};
    vecs[12] = '{1'b0, 4'h2, 16'h0000, 2'b11, 0,   0, 16'hA522, 1'b0};
    vecs[13] = '{1'b1, 4'hF, 16'h5678, 2'b01, 7,   0, 16'hA578, 1'b0};
    vecs[14] = '{1'b0, 4'hF, 16'h0000, 2'b11, 0,   0, 16'hA578, 1'b0};
    vecs[15] = '{1'b0, 4'h5, 16'h0000, 2'b11, 0,   5, 16'hFF34, 1'b0};
    vecs[16] = '{1'b0, 4'h0, 16'h0000, 2'b11, 0,   0, 16'hA5A5, 1'b0};

    idle_bus();
    rst_ni = 1'b0;
    @(negedge clk);
    check("rst_dat_o", 32'(dat_o), 32'(0));
    check("rst_ack", 32'(ack_o), 32'(1'b0));
    check("rst_err", 32'(err_o), 32'(1'b0));
    check("rst_reg_we", 32'(reg_we_o), 32'(1'b0));
    check("rst_reg_adr", 32'(reg_adr_o), 32'(0));
    check("rst_reg_dat", 32'(reg_dat_o), 32'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) xfer(vecs[i]);

    // cyc/stb dropped right after a write is accepted: handshake still
    // completes, ack pulses for exactly one clock.
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = 4'h9; dat_i = 16'h0F0F; sel_i = 2'b11; reg_rdy_i = 1'b0;
    sb_q.push_back(16'h0F0F);
    @(posedge clk); @(negedge clk);
    idle_bus();
    check("drop_reg_we", 32'(reg_we_o), 32'(1'b1));
    pop_cmp("drop_reg_dat", reg_dat_o);
    lat = 0;
    for (int n = 1; n <= BOUND; n++) begin
      reg_rdy_i = (n > 3);
      @(posedge clk); @(negedge clk);
      if (ack_o) begin
        lat = n;
        break;
      end
    end
    reg_rdy_i = 1'b0;
    check("drop_ack_latency", 32'(lat), 32'(4));
    @(posedge clk); @(negedge clk);
    check("drop_ack_pulse", 32'(ack_o), 32'(1'b0));
    v = '{1'b0, 4'h9, 16'h0000, 2'b11, 0, 0, 16'h0F0F, 1'b0};
    xfer(v);

    // async reset in the middle of a pending write
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = 4'hA; dat_i = 16'h1357; sel_i = 2'b11; reg_rdy_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstwr_reg_we", 32'(reg_we_o), 32'(1'b1));
    @(posedge clk); @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("rstwr_reg_we_0", 32'(reg_we_o), 32'(1'b0));
    check("rstwr_reg_dat_0", 32'(reg_dat_o), 32'(0));
    check("rstwr_reg_adr_0", 32'(reg_adr_o), 32'(0));
    check("rstwr_ack_0", 32'(ack_o), 32'(1'b0));
    check("rstwr_err_0", 32'(err_o), 32'(1'b0));
    idle_bus();
    @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    v = '{1'b0, 4'hA, 16'h0000, 2'b11, 0, 0, 16'hA5A5, 1'b0};
    xfer(v);
    v = '{1'b0, 4'h5, 16'h0000, 2'b11, 0, 0, 16'hA5A5, 1'b0};
    xfer(v);

    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
